// File: rtl/ps2_kbrd_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
//   ps2_state_e  : deframing FSM states
//   START_BIT    : level of a valid start bit
//   STOP_BIT     : level of a valid stop bit
//   NDATA        : data bits per frame
//   frame_ok_par : odd-parity check over data byte plus parity bit
package ps2_kbrd_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;
  localparam int unsigned NDATA     = 8;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic frame_ok_par(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_kbrd_rx_filter.sv
// Input conditioning for one PS/2 pin.
//   clk_i  : system clock
//   rst_i  : asynchronous active-high reset (presets the filtered level to 1)
//   pin_i  : raw asynchronous pin
//   filt_o : deglitched level, changes after FILTER_LEN identical synced samples
//   fe_o   : one-cycle strobe on a filtered 1->0 transition
module ps2_kbrd_rx_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic filt_o,
  output logic fe_o
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q;
  logic          filt_q, filt_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter tracks how many consecutive synced samples have disagreed
  // with the filtered level; any agreeing sample restarts it.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
      filt_q <= 1'b1;
      prev_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], pin_i};
      filt_q <= filt_d;
      prev_q <= filt_q;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;
  assign fe_o   = prev_q & ~filt_q;

endmodule

// File: rtl/ps2_kbrd_rx.sv
// PS/2 keyboard receiver feeding scan codes to the picoBlaze.
//   clk, reset               : 100MHz system clock, async active-high reset
//   keyb_clk_in/keyb_data_in : raw PS/2 pins
//   int_ack                  : interrupt acknowledge from the CPU
//   err_clr                  : clears the sticky error flags (set wins)
//   data_out                 : last good scan code
//   interrupt                : new scan code available
//   parity_err/frame_err     : sticky frame rejection flags
//   overrun                  : sticky, good byte arrived while interrupt high
module ps2_kbrd_rx
  import ps2_kbrd_rx_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 20000,
  parameter int unsigned INT_PULSE  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       keyb_clk_in,
  input  logic       keyb_data_in,
  input  logic       int_ack,
  input  logic       err_clr,
  output logic [7:0] data_out,
  output logic       interrupt,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned IW = $clog2(INT_PULSE + 1);
  localparam logic [TW-1:0] TMO_LIM  = TW'(TIMEOUT);
  localparam logic [IW-1:0] INT_LAST = IW'(INT_PULSE - 1);
  localparam logic [2:0]    BIT_LAST = 3'(NDATA - 1);

  logic fe;
  logic dat;
  logic kclk_filt_unused;
  logic dat_fe_unused;

  ps2_kbrd_rx_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_i (clk),
    .rst_i (reset),
    .pin_i (keyb_clk_in),
    .filt_o(kclk_filt_unused),
    .fe_o  (fe)
  );

  ps2_kbrd_rx_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk_i (clk),
    .rst_i (reset),
    .pin_i (keyb_data_in),
    .filt_o(dat),
    .fe_o  (dat_fe_unused)
  );

  ps2_state_e    state_q, state_d;
  logic [7:0]    sr_q, sr_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [IW-1:0] icnt_q, icnt_d;
  logic [7:0]    data_q, data_d;
  logic          int_q, int_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          good_byte, perr_set, ferr_set;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bitcnt_d  = bitcnt_q;
    par_d     = par_q;
    tmo_d     = '0;
    good_byte = 1'b0;
    perr_set  = 1'b0;
    ferr_set  = 1'b0;

    if (state_q == ST_IDLE) begin
      if (fe && dat == START_BIT) begin
        state_d  = ST_SHIFT;
        bitcnt_d = '0;
      end
    end else if (fe) begin
      case (state_q)
        ST_SHIFT: begin
          sr_d = {dat, sr_q[7:1]};
          if (bitcnt_q == BIT_LAST) begin
            state_d = ST_PARITY;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
        ST_PARITY: begin
          par_d   = dat;
          state_d = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          if (dat != STOP_BIT) begin
            ferr_set = 1'b1;
          end else if (!frame_ok_par(sr_q, par_q)) begin
            perr_set = 1'b1;
          end else begin
            good_byte = 1'b1;
          end
        end
      endcase
    end else if (tmo_q == TMO_LIM) begin
      ferr_set = 1'b1;
      state_d  = ST_IDLE;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // A new byte takes priority over both acknowledge and pulse expiry, so the
  // interrupt stays high and its duration restarts.
  always_comb begin
    data_d = data_q;
    int_d  = int_q;
    icnt_d = icnt_q;
    ovr_d  = ovr_q & ~err_clr;
    if (good_byte) begin
      data_d = sr_q;
      int_d  = 1'b1;
      icnt_d = '0;
      if (int_q) ovr_d = 1'b1;
    end else if (int_q) begin
      if (int_ack || icnt_q == INT_LAST) begin
        int_d  = 1'b0;
        icnt_d = '0;
      end else begin
        icnt_d = icnt_q + IW'(1);
      end
    end
    perr_d = perr_set | (perr_q & ~err_clr);
    ferr_d = ferr_set | (ferr_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      bitcnt_q <= '0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
      icnt_q   <= '0;
      data_q   <= '0;
      int_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
      par_q    <= par_d;
      tmo_q    <= tmo_d;
      icnt_q   <= icnt_d;
      data_q   <= data_d;
      int_q    <= int_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign interrupt  = int_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_ps2_kbrd_rx.sv
module tb_ps2_kbrd_rx;

  localparam int FL   = 4;
  localparam int TMO  = 1000;
  localparam int IPUL = 64;
  localparam int H    = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic kclk = 1'b1, kdat = 1'b1;
  logic ack_a = 1'b0, ack_b = 1'b0, err_clr = 1'b0;
  logic [7:0] data_a, data_b;
  logic int_a, perr_a, ferr_a, ovr_a;
  logic int_b, perr_b, ferr_b, ovr_b;

  always #5 clk = ~clk;

  ps2_kbrd_rx #(.FILTER_LEN(FL), .TIMEOUT(TMO), .INT_PULSE(IPUL)) dut (
    .clk(clk), .reset(reset), .keyb_clk_in(kclk), .keyb_data_in(kdat),
    .int_ack(ack_a), .err_clr(err_clr), .data_out(data_a), .interrupt(int_a),
    .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a)
  );

  ps2_kbrd_rx #(.FILTER_LEN(FL), .TIMEOUT(TMO), .INT_PULSE(100000)) dut_ovr (
    .clk(clk), .reset(reset), .keyb_clk_in(kclk), .keyb_data_in(kdat),
    .int_ack(ack_b), .err_clr(err_clr), .data_out(data_b), .interrupt(int_b),
    .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state.
  logic [7:0] exp_data = '0;
  logic exp_perr = 0, exp_ferr = 0, exp_ovr_b = 0, exp_int_b = 0;
  int   exp_rises = 0;

  // Interrupt pulse monitor for the short-pulse instance.
  logic int_a_prev = 1'b0;
  int   rises = 0, hi_cnt = 0, last_w = 0;
  always @(negedge clk) begin
    int_a_prev <= int_a;
    if (int_a && !int_a_prev) rises <= rises + 1;
    if (int_a) hi_cnt <= hi_cnt + 1;
    else begin
      if (hi_cnt != 0) last_w <= hi_cnt;
      hi_cnt <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "/data_a"}, 32'(data_a), 32'(exp_data));
    check_eq({tag, "/data_b"}, 32'(data_b), 32'(exp_data));
    check_eq({tag, "/perr_a"}, 32'(perr_a), 32'(exp_perr));
    check_eq({tag, "/perr_b"}, 32'(perr_b), 32'(exp_perr));
    check_eq({tag, "/ferr_a"}, 32'(ferr_a), 32'(exp_ferr));
    check_eq({tag, "/ferr_b"}, 32'(ferr_b), 32'(exp_ferr));
    check_eq({tag, "/ovr_a"}, 32'(ovr_a), 32'd0);
    check_eq({tag, "/ovr_b"}, 32'(ovr_b), 32'(exp_ovr_b));
    check_eq({tag, "/int_a"}, 32'(int_a), 32'd0);
    check_eq({tag, "/int_b"}, 32'(int_b), 32'(exp_int_b));
    check_eq({tag, "/int_rises"}, 32'(rises), 32'(exp_rises));
    if (exp_rises > 0) check_eq({tag, "/int_width"}, 32'(last_w), 32'(IPUL));
  endtask

  // Frame outcome from the protocol rules alone.
  task automatic model_frame(input logic [7:0] b, input logic par, input logic stop);
    if (!stop) exp_ferr = 1'b1;
    else if ($countones({b, par}) % 2 != 1) exp_perr = 1'b1;
    else begin
      exp_data = b;
      if (exp_int_b) exp_ovr_b = 1'b1;
      exp_int_b = 1'b1;
      exp_rises++;
    end
  endtask

  // Drives bits LSB first, one per PS/2 clock period; glitch_at puts a
  // 3-clk low spike on the clock pin during that bit's high phase.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_at);
    for (int i = 0; i < nbits; i++) begin
      kdat = bits[i];
      wait_clks(H / 2);
      if (i == glitch_at) begin
        kclk = 1'b0; wait_clks(3); kclk = 1'b1; wait_clks(H / 2 - 3);
      end else wait_clks(H / 2);
      kclk = 1'b0;
      wait_clks(H);
      kclk = 1'b1;
    end
    kdat = 1'b1;
    wait_clks(H);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic par, input logic stop);
    return {stop, par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop, input int glitch_at);
    logic par, stop;
    par  = ($countones(b) % 2 == 0) ^ bad_par;
    stop = ~bad_stop;
    send_bits(make_frame(b, par, stop), 11, glitch_at);
    wait_clks(100);
    model_frame(b, par, stop);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1; wait_clks(1); err_clr = 1'b0; wait_clks(1);
    exp_perr = 0; exp_ferr = 0; exp_ovr_b = 0;
  endtask

  task automatic pulse_ack_b();
    ack_b = 1'b1; wait_clks(1); ack_b = 1'b0; wait_clks(1);
    exp_int_b = 0;
  endtask

  initial begin
    #(400000 * 10);
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  initial begin
    wait_clks(5);
    check_all("reset_held");
    reset = 1'b0;
    wait_clks(20);
    check_all("after_reset");

    // Good frame, full-length interrupt pulse.
    send_frame(8'h1C, 0, 0, -1);
    check_eq("good_1C", 32'(data_a), 32'h1C);
    check_all("good_1C");

    // Bad parity: byte discarded, no interrupt, flag clears on err_clr.
    send_frame(8'hF0, 1, 0, -1);
    check_eq("par_err_set", 32'(perr_a), 32'd1);
    check_all("bad_par");
    pulse_err_clr();
    check_eq("par_err_clr", 32'(perr_a), 32'd0);
    pulse_ack_b();
    check_all("clr1");

    // Timeout: start + 5 data bits, then the clock stops.
    send_bits(make_frame(8'h55, 1'b1, 1'b1), 6, -1);
    wait_clks(TMO - 2 * H - 40);
    check_eq("tmo_early", 32'(ferr_a), 32'd0);
    wait_clks(80);
    check_eq("tmo_fired", 32'(ferr_a), 32'd1);
    exp_ferr = 1'b1;
    wait_clks(250);
    check_all("timeout");
    send_frame(8'h1C, 0, 0, -1);
    check_all("after_timeout");
    pulse_err_clr();
    pulse_ack_b();

    // Clock glitches while idle (with data low) and mid-shift.
    kdat = 1'b0; wait_clks(3);
    kclk = 1'b0; wait_clks(3); kclk = 1'b1;
    wait_clks(4); kdat = 1'b1; wait_clks(30);
    check_all("idle_glitch");
    send_frame(8'h5A, 0, 0, 3);
    check_eq("glitch_5A", 32'(data_a), 32'h5A);
    check_all("glitch_frame");

    // Back-to-back bytes without acknowledge on the long-pulse instance.
    pulse_ack_b();
    send_frame(8'h1C, 0, 0, -1);
    send_frame(8'hF0, 0, 0, -1);
    check_eq("ovr_data", 32'(data_b), 32'hF0);
    check_eq("ovr_flag", 32'(ovr_b), 32'd1);
    check_all("overrun");
    ack_b = 1'b1; wait_clks(1);
    check_eq("ack_drop", 32'(int_b), 32'd0);
    ack_b = 1'b0; exp_int_b = 0; wait_clks(1);
    pulse_err_clr();

    // Reset after the 4th data bit.
    send_bits(make_frame(8'hA7, 1'b1, 1'b1), 5, -1);
    reset = 1'b1;
    exp_data = '0; exp_perr = 0; exp_ferr = 0; exp_ovr_b = 0; exp_int_b = 0;
    wait_clks(3);
    check_all("reset_mid");
    reset = 1'b0;
    wait_clks(20);
    send_frame(8'h29, 0, 0, -1);
    check_eq("after_rst_29", 32'(data_a), 32'h29);
    check_all("after_rst");

    // Randomised frames against the model.
    for (int n = 0; n < 12; n++) begin
      logic [7:0] b;
      int kind;
      b    = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) pulse_ack_b();
      if ($urandom_range(0, 3) == 0) pulse_err_clr();
      send_frame(b, kind == 2, kind == 3, -1);
      check_all($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
